serial_adder4x4: RTL and testbench

//  Bit-serial adder: the complement of the ripple 4-bit subtractor in the arithmetic unit.

---
 rtl/serial_adder4x4_if.sv | 27 ++
 rtl/serial_adder4x4.sv | 118 +++++++++++
 tb/tb_serial_adder4x4.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder4x4_if.sv
// Purpose: handshake and data bundle between the calculator control FSM and the
//          bit-serial adder.
// Ports:   master = control side (drives start/A/B/Cin, sees busy/done/S/Co/OV);
//          slave  = adder side.
interface serial_adder4x4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             OV;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Co, OV
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Co, OV
  );
endinterface

// File: rtl/serial_adder4x4.sv
// Purpose: bit-serial adder, S = A + B + Cin, one bit per clock LSB first, using a
//          single full-adder slice and a carry flip-flop. Done one cycle after the
//          last bit; start is sampled only in IDLE (ignored while busy).
// Ports:   clk, rst_n (async active-low); bus (slave modport): start/A/B/Cin in,
//          busy/done/S/Co/OV out. S/Co/OV are registered and hold between operations.
module serial_adder4x4 #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder4x4_if.slave  bus
);

  localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, s_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q, co_q, ov_q;

  logic             sum_bit;
  logic             c_nxt;
  logic             last_step;
  logic [WIDTH-1:0] res_nxt;

  // Full-adder slice on the current LSBs and the carry FF.
  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign last_step = (cnt_q == CNT_LAST);
  // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
  assign res_nxt   = {sum_bit, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      RUN:  bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            c_q   <= bus.Cin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_nxt;
          c_q   <= c_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          // On the MSB step c_q is the carry into the MSB, so the overflow flag
          // is formed here and the visible outputs update as DONE is entered.
          if (last_step) begin
            s_q  <= res_nxt;
            co_q <= c_nxt;
            ov_q <= c_q ^ c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.S  = s_q;
  assign bus.Co = co_q;
  assign bus.OV = ov_q;

endmodule

// File: tb/tb_serial_adder4x4.sv
module tb_serial_adder4x4;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_adder4x4_if #(.WIDTH(W)) bus ();

  serial_adder4x4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: start presented for exactly one rising edge, operands scrambled
  // right after it. Done is expected at the (W+1)-th falling edge after start is set.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [3:0] es, input logic eco, input logic eov,
                        input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.A     = 4'($urandom);
        bus.B     = 4'($urandom);
        bus.Cin   = 1'($urandom);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"},  lat, W + 1);
    check({tag, "_S"},    bus.S,  es);
    check({tag, "_Co"},   bus.Co, eco);
    check({tag, "_OV"},   bus.OV, eov);
    @(negedge clk);
    check({tag, "_pulse"}, bus.done, 1'b0);
    check({tag, "_idle"},  bus.busy, 1'b0);
  endtask

  initial begin
    int         npulses;
    int         sa, sb, t;
    logic [4:0] full;
    logic       eov;

    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_S",    bus.S,    4'h0);
    check("rst_Co",   bus.Co,   1'b0);
    check("rst_OV",   bus.OV,   1'b0);
    rst_n = 1'b1;

    // Directed vectors
    run_op(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1, "v5p3");
    run_op(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, "vFp1");
    run_op(4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0, "v7p8c");
    run_op(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, "v8p8");

    // start held 10 edges; A changes after the first edge. Second op must be
    // sampled in IDLE (start ignored in DONE) and use A=6.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 4'h1;
    bus.B     = 4'h2;
    bus.Cin   = 1'b0;
    npulses   = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1)  bus.A = 4'h6;
      if (i == 10) bus.start = 1'b0;
      if (bus.done) begin
        npulses++;
        if (npulses == 1) begin
          check("bb1_at", i, 5);
          check("bb1_S",  bus.S,  4'h3);
          check("bb1_OV", bus.OV, 1'b0);
        end else if (npulses == 2) begin
          check("bb2_at", i, 11);
          check("bb2_S",  bus.S,  4'h8);
          check("bb2_OV", bus.OV, 1'b1);
        end
      end
    end
    check("bb_pulses", npulses, 2);

    // Reset mid-operation at cnt=2
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 4'h9;
    bus.B     = 4'h4;
    bus.Cin   = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_busy", bus.busy, 1'b0);
    check("mid_done", bus.done, 1'b0);
    check("mid_S",    bus.S,    4'h0);
    check("mid_Co",   bus.Co,   1'b0);
    check("mid_OV",   bus.OV,   1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    npulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) npulses++;
    end
    check("mid_nodone", npulses, 0);
    check("mid_idle",   bus.busy, 1'b0);
    run_op(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0, "after_rst");

    // Exhaustive sweep against integer arithmetic
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          full = 5'(a + b + c);
          sa   = (a >= 8) ? a - 16 : a;
          sb   = (b >= 8) ? b - 16 : b;
          t    = sa + sb + c;
          eov  = (t > 7) || (t < -8);
          run_op(4'(a), 4'(b), 1'(c), full[3:0], full[4], eov, "exh");
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
